tile_row_serializer: RTL and testbench
======================================

# tile_row_serializer

Parallel-in, serial-out pixel serializer for the tile video path. Accepts one packed tile row (PIX_PER_ROW pixels of PIX_W bits) from the tile fetch logic over a valid/ready handshake, then emits one pixel per downstream `pix_en` strobe to the pixel pipeline. A one-row holding register behind the shift register allows the next row to be fetched while the current row is shifting, so back-to-back rows produce gap-free pixel output.

## Interface
- `PIX_W`, 2, bits per pixel.
- `PIX_PER_ROW`, 8, pixels per row; must be at least 2.
- `clk`  in  1  clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `clr`  in  1  synchronous flush; priority over all other inputs except `reset`.
- `row_data`  in  PIX_W*PIX_PER_ROW  packed row; pixel 0 is `[PIX_W-1:0]`.
- `row_flip`  in  1  horizontal flip for this row; used only with `TILE_HFLIP_EN`.
- `row_valid`  in  1  `row_data`/`row_flip` are valid.
- `row_ready`  out  1  holding register can accept a row.
- `pix_en`  in  1  downstream consumes the current pixel this cycle.
- `pix_out`  out  PIX_W  current pixel; 0 when `pix_valid` is 0.
- `pix_valid`  out  1  shift register holds an unconsumed pixel.
- `row_last`  out  1  current pixel is the final pixel of its row.
- `underrun`  out  1  sticky flag: `pix_en` arrived while `pix_valid` was 0.

## Operation
- Storage:
  - holding register `hold` plus `hold_full` flag;
  - shift register `sh`;
  - state `EMPTY`/`SHIFT`;
  - pixel index `idx`, `$clog2(PIX_PER_ROW)` bits.
- `row_ready = ~hold_full & ~reset`.
- A row is accepted when `row_valid && row_ready`. `hold` captures `row_data` and `row_flip`, and `hold_full` is set.
- Transfer from `hold` to `sh` occurs when `hold_full` and either:
  - the state is `EMPTY`, or
  - the state is `SHIFT` with `pix_en` and `idx==PIX_PER_ROW-1`.
- On transfer: `idx` is set to 0, the state goes to `SHIFT`, and `hold_full` is cleared. An accept and a transfer cannot coincide, because `row_ready` is 0 while `hold_full` is 1.
- In `SHIFT` with `pix_en`:
  - `sh` shifts right by `PIX_W` and `idx` increments.
  - At `idx==PIX_PER_ROW-1`: a transfer happens if one is pending; otherwise the state goes to `EMPTY` and `idx` is set to 0.
- `pix_valid = (state==SHIFT)`.
- `pix_out = pix_valid ? sh[PIX_W-1:0] : 0`.
- `row_last = pix_valid && idx==PIX_PER_ROW-1`.
- `pix_en` while `pix_valid==0` sets `underrun`. No state change and no pixel emitted. `underrun` is cleared only by `clr` or `reset`.
- `clr`: clears `hold_full`, sets the state to `EMPTY`, sets `idx` to 0 and clears `underrun`. It also blocks acceptance of `row_data` in that cycle.
- Reset values:
  - `pix_out=0`, `pix_valid=0`, `row_last=0`, `underrun=0`;
  - `row_ready=0` while `reset` is high, 1 in the first cycle after release;
  - internal `hold_full=0`, `idx=0`, state `EMPTY`.
- Reset asserted mid-row discards both the held row and the shifting row.

## Timing
- Accept at edge N gives `hold_full` after N; transfer at edge N+1; `pix_valid`, with pixel 0, after N+1. Latency from accept to first pixel is 2 cycles.
- Each `pix_en` edge advances exactly one pixel.
- Next row's pixel 0 follows pixel `PIX_PER_ROW-1` with zero gap if `hold_full` at that edge.
- `row_ready` returns high the cycle after a transfer. Sustained throughput is one row per `PIX_PER_ROW` consumed pixels.
- All outputs are combinational from registers only; no input-to-output combinational path except `reset` to `row_ready`.

## Configuration
- `TILE_HFLIP_EN` defined:
  - `row_flip` is captured into `hold`.
  - On transfer with flip set, `sh` is loaded with the pixel order reversed, so original pixel `PIX_PER_ROW-1` is emitted first. Bit order within each pixel is unchanged.
- Not defined: the `row_flip` port remains present but is ignored; the flip storage bit is not built.

## Test plan
- Reset then load: `PIX_W=2`, `PIX_PER_ROW=8`, `row_data=16'hE4E4`, `pix_en` constantly 1 → `pix_valid` rises 2 cycles after accept; `pix_out` sequence 0,1,2,3,0,1,2,3; `row_last` high only on the 8th pixel; state returns to `EMPTY`.
- Back-to-back: offer `16'hFFFF` then `16'h0000` with `row_valid` held 1 → second accepted the cycle after the first transfers; 16 contiguous valid pixels, 3×8 then 0×8, no bubble.
- Stall: `pix_en` toggled 1,0,1,0 during a row → `pix_out` holds each value across the low cycle; `row_ready` stays 0 while `hold` is full.
- Underrun: `pix_en=1` with empty pipeline → `underrun=1`, `pix_out=0`; stays set after a new row loads; `clr` clears it.
- Flush/reset mid-row: `clr` (then separately `reset`) at pixel 3 with `hold` full → next cycle `pix_valid=0`, `row_ready=1`, and the old rows never emerge.
- `TILE_HFLIP_EN` build: `row_data=16'hE4E4`, `row_flip=1` → sequence 3,2,1,0,3,2,1,0; with `row_flip=0` → 0,1,2,3,0,1,2,3.

Source files
------------

// File: rtl/tile_row_serializer.sv
// Parallel-in/serial-out tile row serializer with a one-row holding register for gap-free rows.
// Optional horizontal flip when TILE_HFLIP_EN is defined; otherwise row_flip is ignored.
module tile_row_serializer #(
  parameter int PIX_W       = 2,
  parameter int PIX_PER_ROW = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clr,
  input  logic [PIX_W*PIX_PER_ROW-1:0] row_data,
  input  logic                         row_flip,
  input  logic                         row_valid,
  output logic                         row_ready,
  input  logic                         pix_en,
  output logic [PIX_W-1:0]             pix_out,
  output logic                         pix_valid,
  output logic                         row_last,
  output logic                         underrun
);

  localparam int ROW_W = PIX_W * PIX_PER_ROW;
  localparam int IDX_W = $clog2(PIX_PER_ROW);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(PIX_PER_ROW - 1);

  typedef enum logic {EMPTY, SHIFT} state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [ROW_W-1:0] sh_q, sh_d;
  logic [ROW_W-1:0] hold_q;
  logic             hold_full_q, hold_full_d;
  logic             underrun_q, underrun_d;
  logic [ROW_W-1:0] load_row;
  logic             accept, xfer, at_last;

  assign row_ready = ~hold_full_q & ~reset;
  assign accept    = row_valid & row_ready & ~clr;
  assign at_last   = (idx_q == IDX_LAST);
  // Refill from hold when idle, or exactly as the last pixel of the current row is consumed.
  assign xfer      = ~clr & hold_full_q &
                     ((state_q == EMPTY) | (pix_en & at_last));

`ifdef TILE_HFLIP_EN
  logic             hold_flip_q;
  logic [ROW_W-1:0] hold_rev;

  for (genvar i = 0; i < PIX_PER_ROW; i++) begin : g_rev
    assign hold_rev[i*PIX_W +: PIX_W] = hold_q[(PIX_PER_ROW-1-i)*PIX_W +: PIX_W];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       hold_flip_q <= 1'b0;
    else if (accept) hold_flip_q <= row_flip;
  end

  assign load_row = hold_flip_q ? hold_rev : hold_q;
`else
  logic unused_row_flip;
  assign unused_row_flip = row_flip;
  assign load_row        = hold_q;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= EMPTY;
      idx_q       <= '0;
      sh_q        <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      underrun_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      sh_q        <= sh_d;
      hold_full_q <= hold_full_d;
      underrun_q  <= underrun_d;
      if (accept) hold_q <= row_data;
    end
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    sh_d        = sh_q;
    hold_full_d = hold_full_q;
    underrun_d  = underrun_q;
    if (clr) begin
      state_d     = EMPTY;
      idx_d       = '0;
      hold_full_d = 1'b0;
      underrun_d  = 1'b0;
    end else begin
      if (pix_en && state_q == EMPTY) underrun_d = 1'b1;
      if (accept) hold_full_d = 1'b1;
      if (xfer) begin
        sh_d        = load_row;
        idx_d       = '0;
        state_d     = SHIFT;
        hold_full_d = 1'b0;
      end else if (state_q == SHIFT && pix_en) begin
        sh_d = sh_q >> PIX_W;
        if (at_last) begin
          state_d = EMPTY;
          idx_d   = '0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
    end
  end

  assign pix_valid = (state_q == SHIFT);
  assign pix_out   = pix_valid ? sh_q[PIX_W-1:0] : '0;
  assign row_last  = pix_valid & at_last;
  assign underrun  = underrun_q;

endmodule

// File: tb/tb_tile_row_serializer.sv
// Directed bench for tile_row_serializer: load, back-to-back, stall, underrun, flush, reset, flip.
module tb_tile_row_serializer;

  localparam int PIX_W       = 2;
  localparam int PIX_PER_ROW = 8;

  logic        clk = 1'b0;
  logic        reset, clr, row_flip, row_valid, pix_en;
  logic [15:0] row_data;
  logic        row_ready, pix_valid, row_last, underrun;
  logic [1:0]  pix_out;

  int n_chk  = 0;
  int n_fail = 0;

  tile_row_serializer #(.PIX_W(PIX_W), .PIX_PER_ROW(PIX_PER_ROW)) dut (
    .clk(clk), .reset(reset), .clr(clr),
    .row_data(row_data), .row_flip(row_flip), .row_valid(row_valid), .row_ready(row_ready),
    .pix_en(pix_en), .pix_out(pix_out), .pix_valid(pix_valid),
    .row_last(row_last), .underrun(underrun)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one row, wait for accept and transfer; pixel 0 is valid afterwards.
  task automatic load_row(input logic [15:0] d, input logic f);
    row_data  = d;
    row_flip  = f;
    row_valid = 1'b1;
    tick();
    row_valid = 1'b0;
    chk("load_not_yet_valid", pix_valid, 0);
    tick();
    chk("load_valid_2cyc", pix_valid, 1);
  endtask

  // Drain one E4E4 row with pix_en held high; rev selects the flipped order.
  task automatic drain_e4(input string tag, input logic rev);
    pix_en = 1'b1;
    for (int k = 0; k < PIX_PER_ROW; k++) begin
      chk({tag, "_valid"}, pix_valid, 1);
      chk({tag, "_pix"}, pix_out, rev ? 3 - (k % 4) : k % 4);
      chk({tag, "_last"}, row_last, (k == PIX_PER_ROW - 1) ? 1 : 0);
      tick();
    end
    pix_en = 1'b0;
    chk({tag, "_empty"}, pix_valid, 0);
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; row_flip = 1'b0; row_valid = 1'b0; pix_en = 1'b0;
    row_data = 16'h0;
    #12;
    chk("rst_ready", row_ready, 0);
    chk("rst_valid", pix_valid, 0);
    chk("rst_pix", pix_out, 0);
    chk("rst_last", row_last, 0);
    chk("rst_underrun", underrun, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("post_rst_ready", row_ready, 1);

    // Basic load and drain.
    load_row(16'hE4E4, 1'b0);
    chk("load_ready_back", row_ready, 1);
    drain_e4("seq", 1'b0);
    chk("seq_no_underrun", underrun, 0);

    // Back-to-back rows: second accepted right after first transfers, no bubble.
    row_data = 16'hFFFF; row_valid = 1'b1;
    tick();
    row_data = 16'h0000;
    chk("b2b_hold_full", row_ready, 0);
    tick();
    chk("b2b_ready_after_xfer", row_ready, 1);
    pix_en = 1'b1;
    for (int k = 0; k < 2 * PIX_PER_ROW; k++) begin
      chk("b2b_valid", pix_valid, 1);
      chk("b2b_pix", pix_out, (k < PIX_PER_ROW) ? 3 : 0);
      chk("b2b_last", row_last, (k % PIX_PER_ROW == PIX_PER_ROW - 1) ? 1 : 0);
      tick();
      if (k == 0) begin
        row_valid = 1'b0;
        chk("b2b_second_accepted", row_ready, 0);
      end
    end
    pix_en = 1'b0;
    chk("b2b_empty", pix_valid, 0);

    // Stall with hold full, then flush at pixel 3.
    row_data = 16'hE4E4; row_valid = 1'b1;
    tick();
    tick();
    tick();
    row_valid = 1'b0;
    chk("stall_hold_full", row_ready, 0);
    for (int s = 0; s < 4; s++) begin
      pix_en = (s % 2 == 0);
      tick();
      chk("stall_pix", pix_out, (s < 2) ? 1 : 2);
      chk("stall_ready", row_ready, 0);
    end
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    chk("pre_clr_pix3", pix_out, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("clr_valid", pix_valid, 0);
    chk("clr_ready", row_ready, 1);
    chk("clr_pix", pix_out, 0);
    tick();
    tick();
    chk("clr_no_old_row", pix_valid, 0);

    // clr blocks acceptance in its own cycle.
    clr = 1'b1; row_valid = 1'b1; row_data = 16'hFFFF;
    tick();
    clr = 1'b0; row_valid = 1'b0;
    chk("clr_block_ready", row_ready, 1);
    tick();
    chk("clr_block_valid", pix_valid, 0);

    // Async reset mid-row with hold full.
    row_data = 16'hE4E4; row_valid = 1'b1;
    tick();
    tick();
    tick();
    row_valid = 1'b0;
    pix_en = 1'b1;
    tick();
    tick();
    tick();
    pix_en = 1'b0;
    chk("pre_rst_pix3", pix_out, 3);
    #2 reset = 1'b1;
    #1;
    chk("midrst_ready", row_ready, 0);
    chk("midrst_valid", pix_valid, 0);
    tick();
    reset = 1'b0;
    #1;
    chk("midrst_ready_rel", row_ready, 1);
    tick();
    tick();
    chk("midrst_no_old_row", pix_valid, 0);

    // Underrun: sticky across a new row, cleared by clr.
    pix_en = 1'b1;
    tick();
    pix_en = 1'b0;
    chk("udr_set", underrun, 1);
    chk("udr_pix", pix_out, 0);
    chk("udr_valid", pix_valid, 0);
    load_row(16'hFFFF, 1'b0);
    chk("udr_sticky", underrun, 1);
    chk("udr_row_pix", pix_out, 3);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("udr_clr", underrun, 0);
    chk("udr_clr_valid", pix_valid, 0);

    // Flip: reversed order only when the feature is built.
    load_row(16'hE4E4, 1'b1);
`ifdef TILE_HFLIP_EN
    drain_e4("flip1", 1'b1);
`else
    drain_e4("flip1", 1'b0);
`endif
    load_row(16'hE4E4, 1'b0);
    drain_e4("flip0", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
